// File: rtl/usb_rx_nrzi_unstuff.sv
// USB receive back end: NRZI decode, SYNC hunt, bit-unstuffing and LSB-first byte assembly.
// Define USB_RX_HS_EOP_EN to treat a byte-aligned stuff violation as a clean high-speed EOP.
module usb_rx_nrzi_unstuff #(
    parameter int unsigned SYNC_MIN = 12,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clock_480,
    input  logic       reset,
    input  logic       data_in,
    input  logic       se0,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_error
);

    typedef enum logic [1:0] {StIdle, StSync, StData, StStuffAbort} state_e;

    state_e           state_q, state_d;
    logic             prev_line_q;
    logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
    logic [2:0]       ones_cnt_q, ones_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [6:0]       shreg_q, shreg_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_active_q, rx_active_d;
    logic             rx_error_q, rx_error_d;
    logic             dbit;

    always_comb begin
        dbit        = ~(data_in ^ prev_line_q);
        state_d     = state_q;
        zero_cnt_d  = zero_cnt_q;
        ones_cnt_d  = ones_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_error_d  = 1'b0;
        rx_active_d = rx_active_q;

        unique case (state_q)
            StIdle: begin
                rx_active_d = 1'b0;
                ones_cnt_d  = 3'd0;
                bit_cnt_d   = 3'd0;
                if (!dbit) begin
                    zero_cnt_d = CNT_W'(1);
                    state_d    = StSync;
                end else begin
                    zero_cnt_d = '0;
                end
            end
            StSync: begin
                if (se0) begin
                    state_d    = StIdle;
                    zero_cnt_d = '0;
                end else if (!dbit) begin
                    if (zero_cnt_q != '1) zero_cnt_d = zero_cnt_q + 1'b1;
                end else if (zero_cnt_q >= CNT_W'(SYNC_MIN)) begin
                    // The SYNC-terminating 1 already counts toward the stuffing run.
                    state_d     = StData;
                    rx_active_d = 1'b1;
                    ones_cnt_d  = 3'd1;
                    bit_cnt_d   = 3'd0;
                end else begin
                    state_d    = StIdle;
                    zero_cnt_d = '0;
                end
            end
            StData: begin
                if (se0) begin
                    state_d     = StIdle;
                    rx_active_d = 1'b0;
                    rx_error_d  = (bit_cnt_q != 3'd0);
                    bit_cnt_d   = 3'd0;
                    ones_cnt_d  = 3'd0;
                end else if (ones_cnt_q == 3'd6 && !dbit) begin
                    ones_cnt_d = 3'd0;
                end else if (ones_cnt_q == 3'd6) begin
                    state_d     = StStuffAbort;
                    rx_active_d = 1'b0;
                    bit_cnt_d   = 3'd0;
                    ones_cnt_d  = 3'd0;
`ifdef USB_RX_HS_EOP_EN
                    rx_error_d  = (bit_cnt_q != 3'd7);
`else
                    rx_error_d  = 1'b1;
`endif
                end else begin
                    shreg_d    = {dbit, shreg_q[6:1]};
                    ones_cnt_d = dbit ? ones_cnt_q + 3'd1 : 3'd0;
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {dbit, shreg_q};
                        rx_valid_d = 1'b1;
                    end
                end
            end
            StStuffAbort: begin
                // bit_cnt is reused here to count consecutive decoded zeros.
                rx_active_d = 1'b0;
                if (se0 || (!dbit && bit_cnt_q == 3'd7)) begin
                    state_d   = StIdle;
                    bit_cnt_d = 3'd0;
                end else if (!dbit) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    bit_cnt_d = 3'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_480) begin
        if (reset) begin
            state_q     <= StIdle;
            prev_line_q <= 1'b1;
            zero_cnt_q  <= '0;
            ones_cnt_q  <= 3'd0;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 7'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_active_q <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_line_q <= data_in;
            zero_cnt_q  <= zero_cnt_d;
            ones_cnt_q  <= ones_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_active_q <= rx_active_d;
            rx_error_q  <= rx_error_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_active = rx_active_q;
    assign rx_error  = rx_error_q;

endmodule

// File: tb/tb_usb_rx_nrzi_unstuff.sv
// Self-checking bench for usb_rx_nrzi_unstuff: NRZI/stuffing line model plus a byte scoreboard.
`timescale 1ns/1ps
module tb_usb_rx_nrzi_unstuff;

    logic       clock_480 = 1'b0;
    logic       reset;
    logic       data_in;
    logic       se0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_error;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_valid = 0;
    int         n_err   = 0;
    logic       active_prev = 1'b0;
    logic [7:0] exp_q[$];
    logic       line = 1'b1;
    int         tb_ones = 0;

    usb_rx_nrzi_unstuff dut (
        .clock_480 (clock_480),
        .reset     (reset),
        .data_in   (data_in),
        .se0       (se0),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_active (rx_active),
        .rx_error  (rx_error)
    );

    always #5 clock_480 = ~clock_480;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard and protocol monitor, sampled away from the active edge.
    always @(negedge clock_480) begin
        if (rx_valid) begin
            n_valid <= n_valid + 1;
            check_eq("valid_while_active", {31'd0, rx_active}, 32'd1);
            check_eq("sb_has_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check_eq("sb_byte", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
        if (rx_error) begin
            n_err <= n_err + 1;
            check_eq("error_while_active", {31'd0, active_prev}, 32'd1);
        end
        active_prev <= rx_active;
    end

    task automatic tick();
        @(posedge clock_480);
        #1;
    endtask

    task automatic send_dbit(input logic b);
        if (!b) line = ~line;
        data_in = line;
        se0     = 1'b0;
        tick();
    endtask

    task automatic idle_j(input int n);
        line    = 1'b1;
        data_in = 1'b1;
        se0     = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_se0();
        line    = 1'b0;
        data_in = 1'b0;
        se0     = 1'b1;
        tick();
        idle_j(6);
    endtask

    task automatic send_sync_zeros(input int nz);
        for (int i = 0; i < nz; i++) send_dbit(1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back(b);
        for (int i = 0; i < 8; i++) begin
            send_dbit(b[i]);
            tb_ones = b[i] ? tb_ones + 1 : 0;
            if (tb_ones == 6) begin
                send_dbit(1'b0);
                tb_ones = 0;
            end
        end
    endtask

    initial begin
        int v0, e0;
        reset   = 1'b1;
        data_in = 1'b1;
        se0     = 1'b0;
        repeat (3) tick();
        check_eq("rst_rx_data", {24'd0, rx_data}, 32'h00);
        check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("rst_rx_active", {31'd0, rx_active}, 32'd0);
        check_eq("rst_rx_error", {31'd0, rx_error}, 32'd0);

        // 1: idle J line
        reset = 1'b0;
        idle_j(20);
        check_eq("idle_active", {31'd0, rx_active}, 32'd0);
        check_eq("idle_data", {24'd0, rx_data}, 32'h00);
        check_eq("idle_valid_cnt", n_valid, 0);
        check_eq("idle_err_cnt", n_err, 0);

        // 2: single byte 0xA5 with exact timing
        send_sync_zeros(16);
        check_eq("t2_active_pre", {31'd0, rx_active}, 32'd0);
        send_dbit(1'b1);
        tb_ones = 1;
        check_eq("t2_active_rise", {31'd0, rx_active}, 32'd1);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            b = 8'hA5;
            if (i == 7) check_eq("t2_valid_pre", {31'd0, rx_valid}, 32'd0);
            send_dbit(b[i]);
        end
        check_eq("t2_valid", {31'd0, rx_valid}, 32'd1);
        check_eq("t2_data", {24'd0, rx_data}, 32'hA5);
        line    = 1'b0;
        data_in = 1'b0;
        se0     = 1'b1;
        tick();
        check_eq("t2_active_fall", {31'd0, rx_active}, 32'd0);
        check_eq("t2_no_error", {31'd0, rx_error}, 32'd0);
        check_eq("t2_data_hold", {24'd0, rx_data}, 32'hA5);
        idle_j(6);
        check_eq("t2_valid_cnt", n_valid, 1);

        // 3: 0xFF (with stuffed bit) then 0x00
        v0 = n_valid;
        e0 = n_err;
        send_sync_zeros(14);
        send_dbit(1'b1);
        tb_ones = 1;
        send_byte(8'hFF);
        send_byte(8'h00);
        send_se0();
        check_eq("t3_valid_cnt", n_valid - v0, 2);
        check_eq("t3_err_cnt", n_err - e0, 0);
        check_eq("t3_last_data", {24'd0, rx_data}, 32'h00);

        // 4: stuff violation starting on a byte boundary
        v0 = n_valid;
        e0 = n_err;
        send_sync_zeros(12);
        send_dbit(1'b1);
        send_dbit(1'b0);
        for (int i = 0; i < 7; i++) send_dbit(1'b1);
`ifdef USB_RX_HS_EOP_EN
        check_eq("t4_error_pulse", {31'd0, rx_error}, 32'd0);
`else
        check_eq("t4_error_pulse", {31'd0, rx_error}, 32'd1);
`endif
        check_eq("t4_active", {31'd0, rx_active}, 32'd0);
        idle_j(4);
        check_eq("t4_active_idle", {31'd0, rx_active}, 32'd0);
        send_se0();
        check_eq("t4_valid_cnt", n_valid - v0, 0);
`ifdef USB_RX_HS_EOP_EN
        check_eq("t4_err_cnt", n_err - e0, 0);
`else
        check_eq("t4_err_cnt", n_err - e0, 1);
`endif

        // 5: SYNC too short
        v0 = n_valid;
        send_sync_zeros(8);
        send_dbit(1'b1);
        check_eq("t5_active", {31'd0, rx_active}, 32'd0);
        for (int i = 0; i < 8; i++) send_dbit(1'b0);
        idle_j(4);
        check_eq("t5_active_late", {31'd0, rx_active}, 32'd0);
        check_eq("t5_valid_cnt", n_valid - v0, 0);

        // 6: reset mid-byte, then a clean packet
        v0 = n_valid;
        e0 = n_err;
        send_sync_zeros(12);
        send_dbit(1'b1);
        for (int i = 0; i < 4; i++) send_dbit(i[0]);
        check_eq("t6_active_pre", {31'd0, rx_active}, 32'd1);
        reset   = 1'b1;
        line    = 1'b1;
        data_in = 1'b1;
        tick();
        check_eq("t6_rst_active", {31'd0, rx_active}, 32'd0);
        check_eq("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("t6_rst_error", {31'd0, rx_error}, 32'd0);
        check_eq("t6_rst_data", {24'd0, rx_data}, 32'h00);
        reset = 1'b0;
        idle_j(5);
        check_eq("t6_valid_after_rst", n_valid - v0, 0);
        check_eq("t6_err_after_rst", n_err - e0, 0);
        send_sync_zeros(12);
        send_dbit(1'b1);
        tb_ones = 1;
        send_byte(8'h3C);
        send_se0();
        check_eq("t6_valid_cnt", n_valid - v0, 1);
        check_eq("t6_data", {24'd0, rx_data}, 32'h3C);
        check_eq("t6_err_cnt", n_err - e0, 0);

        check_eq("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
